stream_mux_rr: RTL and testbench

Parametrised N-input, W-bit stream multiplexer with valid/ready handshakes and a one-entry registered output. It generalises the team's combinational 2:1 gate-level muxes in three ways: input count, data width, and selection mode. Selection is either a fixed select input or round-robin arbitration. It sits between multiple producer streams and a single consumer, for example merging absdiff request streams into one datapath, and it decouples timing through its output register.

---
 rtl/stream_mux_rr.sv | 89 ++++++++
 tb/tb_stream_mux_rr.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-input stream multiplexer with fixed-select or round-robin arbitration
// and a single registered output slot.
module stream_mux_rr #(
  parameter int unsigned nbits   = 4,
  parameter int unsigned ninputs = 4,
  parameter int unsigned sbits   = $clog2(ninputs)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [sbits-1:0]         sel,
  input  logic [ninputs-1:0]       in_val,
  input  logic [ninputs*nbits-1:0] in_msg,
  output logic [ninputs-1:0]       in_rdy,
  output logic                     out_val,
  output logic [nbits-1:0]         out_msg,
  input  logic                     out_rdy
);

  localparam int unsigned last_idx = ninputs - 1;

  logic [ninputs-1:0] grant;
  logic [sbits-1:0]   gidx;
  logic               found;
  logic [nbits-1:0]   gmsg;
  logic [sbits-1:0]   ptr;
  logic [sbits-1:0]   ptr_next;
  logic               space;
  logic               xfer;

  // Grant selection; round-robin scans ptr..n-1 first, then 0..ptr-1.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    if (!mode) begin
      for (int unsigned i = 0; i < ninputs; i++) begin
        if (sel == sbits'(i) && in_val[i]) begin
          grant[i] = 1'b1;
          gidx     = sbits'(i);
          found    = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < ninputs; i++) begin
        if (!found && in_val[i] && sbits'(i) >= ptr) begin
          grant[i] = 1'b1;
          gidx     = sbits'(i);
          found    = 1'b1;
        end
      end
      for (int unsigned i = 0; i < ninputs; i++) begin
        if (!found && in_val[i] && sbits'(i) < ptr) begin
          grant[i] = 1'b1;
          gidx     = sbits'(i);
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gmsg = '0;
    for (int unsigned i = 0; i < ninputs; i++) begin
      if (grant[i]) gmsg = in_msg[i*nbits +: nbits];
    end
  end

  assign space    = !out_val || out_rdy;
  assign in_rdy   = (rst || !space) ? '0 : grant;
  assign xfer     = found && space && !rst;
  assign ptr_next = (gidx == sbits'(last_idx)) ? '0 : gidx + sbits'(1);

  // Output slot and round-robin pointer; a load wins over a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_val <= 1'b0;
      out_msg <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      out_val <= 1'b1;
      out_msg <= gmsg;
      if (mode) ptr <= ptr_next;
    end else if (out_val && out_rdy) begin
      out_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scenario bench for stream_mux_rr: a 4x4-bit instance and a 3x8-bit instance,
// with expected output messages queued per instance and popped on each output transfer.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst;
  logic        mode, out_rdy, out_val;
  logic [1:0]  sel;
  logic [3:0]  in_val, in_rdy, out_msg;
  logic [15:0] in_msg;

  logic        mode3, out_rdy3, out_val3;
  logic [1:0]  sel3;
  logic [2:0]  in_val3, in_rdy3;
  logic [23:0] in_msg3;
  logic [7:0]  out_msg3;

  int errors = 0;
  int checks = 0;
  logic [3:0] q[$];
  logic [7:0] q3[$];
  logic [3:0] msgs4 [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [7:0] msgs3 [3] = '{8'h11, 8'h22, 8'h33};

  stream_mux_rr #(.nbits(4), .ninputs(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_val(in_val), .in_msg(in_msg),
    .in_rdy(in_rdy), .out_val(out_val), .out_msg(out_msg), .out_rdy(out_rdy)
  );

  stream_mux_rr #(.nbits(8), .ninputs(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_val(in_val3), .in_msg(in_msg3),
    .in_rdy(in_rdy3), .out_val(out_val3), .out_msg(out_msg3), .out_rdy(out_rdy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Scoreboard: every output transfer must match the oldest queued message.
  always @(negedge clk) begin
    if (!rst && out_val === 1'b1 && out_rdy === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb4: out_msg=%h delivered, expected no transfer", out_msg);
      end else begin
        logic [3:0] e;
        e = q.pop_front();
        if (out_msg !== e) begin
          errors++;
          $display("FAIL sb4: out_msg=%h expected %h", out_msg, e);
        end
      end
    end
    if (!rst && out_val3 === 1'b1 && out_rdy3 === 1'b1) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL sb3: out_msg=%h delivered, expected no transfer", out_msg3);
      end else begin
        logic [7:0] e3;
        e3 = q3.pop_front();
        if (out_msg3 !== e3) begin
          errors++;
          $display("FAIL sb3: out_msg=%h expected %h", out_msg3, e3);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mode = 1'b1; sel = 2'd0; in_val = 4'b0; in_msg = 16'hDCBA; out_rdy = 1'b1;
    mode3 = 1'b1; sel3 = 2'd0; in_val3 = 3'b0; in_msg3 = 24'h332211; out_rdy3 = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    q.delete();
    q3.delete();
    rst = 1'b0;
  endtask

  task automatic drain();
    in_val = 4'b0; in_val3 = 3'b0; out_rdy = 1'b1; out_rdy3 = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    in_val = 4'hF;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== 4'b0000) begin
        errors++;
        $display("FAIL reset_rdy[%0d]: in_rdy=%b expected 0000", c, in_rdy);
      end
      step();
      checks++;
      if (out_val !== 1'b0) begin
        errors++;
        $display("FAIL reset_val[%0d]: out_val=%b expected 0", c, out_val);
      end
    end
    q.delete();
    q3.delete();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: in_rdy=%b expected 0001", in_rdy);
    end
    q.push_back(4'hA);
    step();
    drain();
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_val = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== 4'b0100) begin
        errors++;
        $display("FAIL fixed_rdy[%0d]: in_rdy=%b expected 0100", c, in_rdy);
      end
      q.push_back(4'hC);
      step();
      checks++;
      if (out_val !== 1'b1 || out_msg !== 4'hC) begin
        errors++;
        $display("FAIL fixed_out[%0d]: val=%b msg=%h expected 1/c", c, out_val, out_msg);
      end
    end
    sel = 2'd3; in_val = 4'b0111;
    @(negedge clk);
    checks++;
    if (in_rdy !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_sel3_rdy: in_rdy=%b expected 0000", in_rdy);
    end
    step();
    checks++;
    if (out_val !== 1'b0) begin
      errors++;
      $display("FAIL fixed_drain: out_val=%b expected 0", out_val);
    end
    drain();
  endtask

  task automatic test_rotation();
    int seq1 [5] = '{0, 1, 2, 3, 0};
    int seq2 [4] = '{1, 3, 1, 3};
    do_reset();
    in_val = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== 4'(1 << seq1[k])) begin
        errors++;
        $display("FAIL rr_all[%0d]: in_rdy=%b expected %b", k, in_rdy, 4'(1 << seq1[k]));
      end
      q.push_back(msgs4[seq1[k]]);
      step();
    end
    in_val = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== 4'(1 << seq2[k])) begin
        errors++;
        $display("FAIL rr_1010[%0d]: in_rdy=%b expected %b", k, in_rdy, 4'(1 << seq2[k]));
      end
      q.push_back(msgs4[seq2[k]]);
      step();
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    in_val = 4'hF;
    @(negedge clk);
    q.push_back(4'hA);
    step();
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== 4'b0000 || out_val !== 1'b1 || out_msg !== 4'hA) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rdy=%b val=%b msg=%h expected 0000/1/a",
                 c, in_rdy, out_val, out_msg);
      end
      step();
    end
    out_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release: in_rdy=%b expected 0010", in_rdy);
    end
    q.push_back(4'hB);
    step();
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    in_val = 4'b0100;
    @(negedge clk);
    q.push_back(4'hC);
    step();
    in_val = 4'b0011;
    @(negedge clk);
    checks++;
    if (in_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_grant: in_rdy=%b expected 0001", in_rdy);
    end
    q.push_back(4'hA);
    step();
    @(negedge clk);
    checks++;
    if (in_rdy !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_ptr1: in_rdy=%b expected 0010", in_rdy);
    end
    q.push_back(4'hB);
    step();
    drain();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    in_val = 4'b0001; out_rdy = 1'b0;
    step();
    in_val = 4'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 4'b0000 || out_val !== 1'b1) begin
      errors++;
      $display("FAIL mid_hold: rdy=%b val=%b expected 0000/1", in_rdy, out_val);
    end
    step();
    checks++;
    if (out_val !== 1'b0 || out_msg !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: val=%b msg=%h expected 0/0", out_val, out_msg);
    end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_sweep();
    int seq [4] = '{0, 1, 2, 0};
    do_reset();
    in_val3 = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_rdy3 !== 3'(1 << seq[k])) begin
        errors++;
        $display("FAIL sweep_rr[%0d]: in_rdy=%b expected %b", k, in_rdy3, 3'(1 << seq[k]));
      end
      q3.push_back(msgs3[seq[k]]);
      step();
    end
    mode3 = 1'b0; sel3 = 2'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_rdy3 !== 3'b000) begin
        errors++;
        $display("FAIL sweep_sel3[%0d]: in_rdy=%b expected 000", k, in_rdy3);
      end
      step();
    end
    checks++;
    if (out_val3 !== 1'b0) begin
      errors++;
      $display("FAIL sweep_drain: out_val=%b expected 0", out_val3);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    test_sweep();
    checks++;
    if (q.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: pending=%0d/%0d expected 0/0", q.size(), q3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
